// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: op encodings, FSM states and op classification.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_MUL  = 4'b0100,
        OP_DIVU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_NOR  = 4'b1100,
        OP_SLTU = 4'b1111
    } op_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic is_iterative(op_t op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned datapath: LSB-first shift-add multiply and restoring divide,
// one step per cycle for WIDTH cycles. lo/hi present the value after the current step.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);

    localparam int CNTW = $clog2(WIDTH + 1);

    // acc: product high half / partial remainder; shreg: multiplier / dividend-quotient
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [CNTW-1:0]  count;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        lo        = '0;
        hi        = '0;
        add_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        rem_shift = {acc, shreg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd};
        if (div_mode) begin
            // A zero divisor always subtracts: quotient fills with ones, remainder collects a.
            if (rem_shift >= {1'b0, opnd}) begin
                hi = rem_diff[WIDTH-1:0];
                lo = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                hi = rem_shift[WIDTH-1:0];
                lo = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi = add_sum[WIDTH:1];
            lo = {add_sum[0], shreg[WIDTH-1:1]};
        end
    end

    // NOTE: the datapath registers are reset too; they are few and a known state eases debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            acc      <= '0;
            shreg    <= op_div ? a : b;
            opnd     <= op_div ? b : a;
            div_mode <= op_div;
            count    <= CNTW'(WIDTH);
        end else if (count != '0) begin
            acc   <= hi;
            shreg <= lo;
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNTW'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops complete in one edge, MUL/DIVU iterate in alu_muldiv
// behind a start/busy/done handshake. All outputs are registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zout,
    output logic             signout,
    output logic             ovf,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t           state;
    op_t              op_e;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic             sc_illegal;
    logic             md_load;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_last;

    assign op_e  = op_t'(op);
    assign shamt = b[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a + ~b + 1'b1;

    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (op_e)
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_NOR:  sc_result = ~(a | b);
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_SLT:  sc_result = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: sc_result = WIDTH'(a < b);
            OP_SLL:  sc_result = a << shamt;
            OP_SRL:  sc_result = a >> shamt;
            OP_SRA:  sc_result = $signed(a) >>> shamt;
            OP_MUL, OP_DIVU: sc_result = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    assign md_load = (state == IDLE) && start && is_iterative(op_e);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (md_load),
        .op_div (op_e == OP_DIVU),
        .a      (a),
        .b      (b),
        .lo     (md_lo),
        .hi     (md_hi),
        .last   (md_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            hi      <= '0;
            zout    <= 1'b0;
            signout <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_iterative(op_e)) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            result  <= sc_result;
                            hi      <= '0;
                            zout    <= (sc_result == '0);
                            signout <= sc_result[MSB];
                            ovf     <= sc_ovf;
                            illegal <= sc_illegal;
                            done    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The final step's value is captured on the same edge it is computed.
                    if (md_last) begin
                        result  <= md_lo;
                        hi      <= md_hi;
                        zout    <= (md_lo == '0);
                        signout <= md_lo[MSB];
                        ovf     <= 1'b0;
                        illegal <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed corner cases, handshake timing,
// abort on reset and randomized ops against a 64-bit arithmetic reference model.
module tb_alu_seq;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zout, signout, ovf, illegal, busy, done;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (result),
        .hi      (hi),
        .zout    (zout),
        .signout (signout),
        .ovf     (ovf),
        .illegal (illegal),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op semantics.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic v, output logic il);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint t;
        logic [63:0] p;
        r = '0; h = '0; v = 1'b0; il = 1'b0;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin r = x + y; t = sx + sy; v = (t > SMAX) || (t < SMIN); end
            4'b0110: begin r = x - y; t = sx - sy; v = (t > SMAX) || (t < SMIN); end
            4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1111: r = (x < y) ? 32'd1 : 32'd0;
            4'b0011: r = x ^ y;
            4'b1100: r = ~(x | y);
            4'b1000: r = x << y[4:0];
            4'b1001: r = x >> y[4:0];
            4'b1010: r = 32'(sx >>> y[4:0]);
            4'b0100: begin p = 64'(x) * 64'(y); r = p[31:0]; h = p[63:32]; end
            4'b0101: begin
                if (y == 0) begin r = '1; h = x; end
                else begin r = x / y; h = x % y; end
            end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input logic [3:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er, eh;
        logic ev, ei;
        model(o, x, y, er, eh, ev, ei);
        check({tag, ".result"},  result,  er);
        check({tag, ".hi"},      hi,      eh);
        check({tag, ".zout"},    zout,    er == 0);
        check({tag, ".signout"}, signout, er[31]);
        check({tag, ".ovf"},     ovf,     ev);
        check({tag, ".illegal"}, illegal, ei);
        check({tag, ".busy"},    busy,    1'b0);
        check({tag, ".done"},    done,    1'b1);
    endtask

    // Counts negedges after the sampling edge until done, bounded.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles = 1;
        busy_cnt = 0;
        while (!done && cycles <= 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        if (!done) check("timeout", done, 1'b1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        int cycles, busy_cnt;
        bit iter;
        iter = (o == 4'b0100) || (o == 4'b0101);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        wait_done(cycles, busy_cnt);
        check({tag, ".latency"}, cycles, iter ? 33 : 1);
        check({tag, ".busy_cycles"}, busy_cnt, iter ? 32 : 0);
        check_outputs(tag, o, x, y);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".hold"}, result, dut.result);
    endtask

    initial begin
        int cycles, busy_cnt;
        bit saw_done;
        logic [3:0]  ro;
        logic [31:0] rx, ry;

        repeat (2) @(negedge clk);
        check("reset.result", result, 0);
        check("reset.hi", hi, 0);
        check("reset.flags", {zout, signout, ovf, illegal, busy, done}, 6'b0);
        rst_n = 1'b1;

        do_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1);
        do_op("sub_zero", 4'b0110, 32'd5, 32'd5);
        do_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1);
        do_op("sltu",     4'b1111, 32'hFFFF_FFFF, 32'd1);
        do_op("sra",      4'b1010, 32'h8000_0000, 32'h21);
        do_op("mul_max",  4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("divu",     4'b0101, 32'd100, 32'd7);
        do_op("divu_z",   4'b0101, 32'd9, 32'd0);
        do_op("illegal",  4'b1110, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'd1);

        // Start ignored while busy; new op accepted in the done cycle with no bubble.
        @(negedge clk);
        start = 1'b1; op = 4'b0100; a = 32'hDEAD_BEEF; b = 32'h0001_2345;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 4'b0010; a = 32'd40; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(cycles, busy_cnt);
        cycles += 6;
        check("mid_start.latency", cycles, 33);
        check_outputs("mid_start", 4'b0100, 32'hDEAD_BEEF, 32'h0001_2345);
        start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check_outputs("b2b_add", 4'b0010, 32'd1, 32'd2);

        // Reset in the middle of a multiply: outputs clear at once, no done follows.
        @(negedge clk);
        start = 1'b1; op = 4'b0100; a = 32'h0F0F_0F0F; b = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort.busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort.result", result, 0);
        check("abort.hi", hi, 0);
        check("abort.flags", {zout, signout, ovf, illegal, busy, done}, 6'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort.no_done", saw_done, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom);
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (ro == 4'b0101 && $urandom_range(0, 1) == 1) ry = ry >> $urandom_range(8, 30);
            do_op($sformatf("rand%0d_op%0h", i, ro), ro, rx, ry);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor of the 32-bit single-cycle ALU in the datapath. Keeps the existing control-line encodings, adds XOR/NOR/SLTU/shifts, and adds iterative unsigned multiply and divide behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle datapath. Every result, flag and HI value is registered.

## Interface
- WIDTH, 32, operand/result width; must be at least 4 and a power of two.
- CNTW, $clog2(WIDTH+1), iteration-counter width (derived; do not override).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  4  operation select (encodings below)
- a, b  in  WIDTH  operands
- result  out  WIDTH  main result
- hi  out  WIDTH  MUL upper product / DIVU remainder; 0 for other ops
- zout  out  1  result == 0
- signout  out  1  result[WIDTH-1]
- ovf  out  1  signed overflow (ADD/SUB only)
- illegal  out  1  op not in the table
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse; all outputs valid from this cycle

## Operation
- Encodings keep the legacy 3-bit codes, zero-extended:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (signed).
  - New: XOR 0011, MUL 0100, DIVU 0101, NOR 1100, SLL 1000, SRL 1001, SRA 1010, SLTU 1111.
- SUB is computed as a + ~b + 1.
- SLT/SLTU write 1 or 0 to result. SLT uses the signed compare result, not the raw sign of the difference.
- Shifts use b[$clog2(WIDTH)-1:0] as the shift amount and ignore the upper bits of b.
- ovf: set when the operand signs require it and the result sign differs. It is 0 for all other ops.
- MUL: unsigned shift-add; 2·WIDTH product; result = low half, hi = high half.
- DIVU: unsigned restoring divide; result = quotient, hi = remainder.
- Divide by zero: result = all ones, hi = a, no other flag.
- Illegal op: result 0, hi 0, illegal=1, done still pulses.
- FSM states: IDLE, RUN.
  - IDLE + start + single-cycle op: register outputs and pulse done next cycle; stay in IDLE.
  - IDLE + start + MUL/DIVU: latch a, b, op; count ← WIDTH; go to RUN.
  - RUN: one iteration per cycle, count decrements. When count reaches 0, register outputs, pulse done, return to IDLE.
- start while busy=1 is ignored; no queueing.
- Outputs hold their last value until the next done.

## Timing
- Reset (asynchronous): state IDLE, count 0. result, hi, zout, signout, ovf, illegal, busy and done are all 0.
- Single-cycle op, start at edge N: done=1 and outputs valid after edge N+1; busy stays 0.
- MUL/DIVU, start at edge N:
  - busy=1 after edges N+1 … N+WIDTH.
  - done=1 and busy=0 after edge N+WIDTH+1.
  - Latency is WIDTH+1 cycles.
- Back-to-back: start may be high in the cycle done is high. A new op starts at the next edge, with no bubble.
- Operand changes during RUN have no effect, because the operands are latched.
- rst_n asserted mid-RUN aborts the operation with no done pulse. Outputs clear immediately.

## Structure
- Package alu_pkg holds:
  - the op_t enum for the 4-bit encodings;
  - the state_t enum (IDLE, RUN);
  - an is_iterative(op) function.
- Sub-module alu_muldiv holds the iterative datapath: accumulator/remainder registers, operand shift registers and the counter. Its ports are load, op_div, a, b, lo, hi and last.
- Top level contains the combinational single-cycle ALU, the FSM and the output registers.

## Test plan
- WIDTH=32. ADD 0x7FFFFFFF + 1 → result 0x80000000, ovf=1, signout=1, done at N+1. SUB 5-5 → zout=1.
- SLT a=-1, b=1 → 1. SLTU with the same operands → 0. SRA 0x80000000 by b=0x21 → 0xC0000000 (shift amount 1).
- MUL 0xFFFFFFFF × 0xFFFFFFFF → result 0x00000001, hi 0xFFFFFFFE. busy high for exactly 32 cycles; done at N+33.
- DIVU 100/7 → result 14, hi 2. DIVU 9/0 → result 0xFFFFFFFF, hi 9.
- Start a MUL. Pulse start with ADD mid-RUN → ignored. Issue ADD in the done cycle → second done exactly 1 cycle later.
- Assert rst_n low at RUN cycle 10 → all outputs 0 asynchronously, no done. Illegal op 1110 → illegal=1, result 0, done at N+1.
